edge_event_arbiter: RTL
=======================

// Module: edge_event_arbiter
//
// PURPOSE
//  Captures rising edges on N independent 1-bit lines (per-line posedge
//  detection), latches each as a pending event and serves events one at a
//  time to one downstream consumer over a valid/ready handshake.
//  Arbitration is round-robin. Sits between raw status/strobe lines and a
//  single event-processing unit that can only take one event per cycle.
//
// PARAMETERS
//  N      4             number of input lines, >= 2
//  ID_W   $clog2(N)     width of out_id (derived; do not override)
//
// PORTS
//  clk        in   1     clock, all logic on posedge
//  rst        in   1     synchronous reset, active-high
//  a          in   N     input lines, synchronous to clk
//  out_valid  out  1     event offered to consumer
//  out_ready  in   1     consumer accepts offered event
//  out_id     out  ID_W  index of line whose event is offered
//  pending    out  N     per-line pending-event flags (registered)
//  overflow   out  1     1-cycle pulse: edge lost on already-pending line
//
// BEHAVIOUR
//  Reset (rst=1 at posedge): a_r, pending, ptr <= 0; state <= IDLE;
//   out_valid, out_id, overflow <= 0. a_r=0 after reset: line held high
//   through reset release yields one edge in first cycle with rst=0.
//  Edge detect: edge[i] = ~a_r[i] & a[i]; a_r <= a every cycle.
//  Pending: set[i] = edge[i]; clr[i] = accept & (out_id == i),
//   accept = out_valid & out_ready. pending[i] <= set[i] | (pending[i] & ~clr[i]).
//   Set wins over clear (new edge on line being accepted stays pending).
//  Overflow: overflow <= |(edge & pending & ~clr); registered, 1 cycle.
//   The event is merged, not counted; pending stays 1.
//  FSM (2 states), out_valid = (state == OFFER):
//   IDLE : if |pending -> OFFER, out_id <= rr_pick(pending, ptr).
//   OFFER: out_id held stable while ~out_ready (no re-arbitration).
//          On accept: ptr <= (out_id+1) mod N;
//            let nxt = pending & ~clr, with bit i set again if set[i].
//            If |nxt: stay OFFER, out_id <= rr_pick(nxt, (out_id+1) mod N).
//            Else -> IDLE.
//  rr_pick(v,p): first set bit of v scanning p, p+1, ..., wrapping N-1 -> 0.
//  Latency: edge on a[i] in cycle t -> pending[i]=1 in t+1 -> out_valid=1 in
//   t+2 from IDLE. Back-to-back: one event per cycle while ready=1 and
//   events pending.
//  Pending set only by edges; a held-high line gives exactly one event.
//  Reset mid-OFFER: offered event dropped; out_valid=0 the cycle after the
//   reset edge. Edges in the reset cycle are ignored.
//
// TESTING
//  1. Single edge: a=4'b0000 -> 4'b0100 at t, ready=1 -> pending=0100 at t+1;
//     valid=1, id=2 at t+2; valid=0 at t+3.
//  2. Simultaneous: a 0000->1111 in one cycle, ready=1 -> ids 0,1,2,3 on
//     consecutive cycles, valid held 4 cycles, no overflow.
//  3. Round-robin fairness: after serving id=1, pending=1011 -> next ids 3,0.
//     Never 0 before 3.
//  4. Backpressure: ready=0 with valid=1, id=2; new edge on line 0 -> id stays
//     2 until ready=1; then 0 is served.
//  5. Overflow: line 1 pending, ready=0, pulse a[1] 0->1->0->1 -> overflow=1
//     for exactly one cycle; line 1 served once.
//  6. Reset: rst=1 during OFFER -> valid=0, pending=0 next cycle.
//     a=0001 held through reset release -> one event id=0.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Captures rising edges on N lines as pending events and serves them one at a
// time, round-robin, to a single consumer over a valid/ready handshake.
module edge_event_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    a,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ID_W-1:0] out_id,
  output logic [N-1:0]    pending,
  output logic            overflow
);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t          r_state;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_pending;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_out_id;
  logic            r_overflow;

  logic [N-1:0]    w_edge;
  logic [N-1:0]    w_clr;
  logic [N-1:0]    w_nxt;
  logic            w_accept;
  logic [ID_W-1:0] w_id_inc;

  // First set bit of v, scanning upward from p and wrapping at N-1.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] v,
                                              input logic [ID_W-1:0] p);
    logic [ID_W-1:0] res;
    logic [ID_W-1:0] sel;
    logic            found;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      sel = ID_W'((32'(p) + k) % N);
      if (!found && v[sel]) begin
        res   = sel;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign w_edge   = ~r_a & a;
  assign w_accept = (r_state == S_OFFER) & out_ready;
  assign w_id_inc = (r_out_id == ID_W'(N - 1)) ? '0 : r_out_id + ID_W'(1);

  always_comb begin
    w_clr = '0;
    if (w_accept) w_clr[r_out_id] = 1'b1;
  end

  // A new edge on the line being accepted re-arms it (set wins over clear).
  assign w_nxt = w_edge | (r_pending & ~w_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_pending  <= '0;
      r_ptr      <= '0;
      r_state    <= S_IDLE;
      r_out_id   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_a        <= a;
      r_pending  <= w_nxt;
      r_overflow <= |(w_edge & r_pending & ~w_clr);
      case (r_state)
        S_IDLE: begin
          if (|r_pending) begin
            r_state  <= S_OFFER;
            r_out_id <= rr_pick(r_pending, r_ptr);
          end
        end
        S_OFFER: begin
          if (out_ready) begin
            r_ptr <= w_id_inc;
            if (|w_nxt) begin
              r_out_id <= rr_pick(w_nxt, w_id_inc);
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = (r_state == S_OFFER);
  assign out_id    = r_out_id;
  assign pending   = r_pending;
  assign overflow  = r_overflow;

endmodule
